// File: rtl/mem_stage.sv
// RV32I memory stage: EX/MEM register, load/store through a req/ready data port,
// load alignment/extension and a single write-back register per retired instruction.
module mem_stage #(
    parameter bit          MISALIGN_CHECK = 1'b1,
    parameter int unsigned DMEM_AW        = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_valid,
    input  logic [4:0]         ex_opcode,
    input  logic [2:0]         ex_func3,
    input  logic [31:0]        ex_alu_out,
    input  logic [31:0]        ex_rs2_data,
    input  logic [4:0]         ex_rd,
    input  logic               ex_reg_write,
    output logic               mem_stall,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [3:0]         dmem_wstrb,
    output logic [31:0]        dmem_wdata,
    input  logic               dmem_ready,
    input  logic [31:0]        dmem_rdata,
    output logic               mem_misaligned,
    output logic               wb_valid,
    output logic [4:0]         wb_rd,
    output logic               wb_reg_write,
    output logic [31:0]        wb_data
);

    localparam int unsigned XLEN = 32;
    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_STORE = 5'b01000;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;
    typedef enum logic {IDLE, ACCESS} state_e;

    typedef struct packed {
        logic            valid;
        logic [4:0]      opcode;
        logic [2:0]      func3;
        logic [XLEN-1:0] alu_out;
        logic [XLEN-1:0] rs2;
        logic [4:0]      rd;
        logic            reg_write;
    } stage_t;

    // Reserved func3 encodings (loads 011/110/111, stores 011/1xx) behave as words.
    function automatic size_e acc_size(input logic [4:0] opcode, input logic [2:0] func3);
        size_e sz;
        case (func3[1:0])
            2'b00:   sz = SZ_B;
            2'b01:   sz = SZ_H;
            default: sz = SZ_W;
        endcase
        if (opcode == OP_STORE && func3[2]) begin
            sz = SZ_W;
        end
        return sz;
    endfunction

    function automatic logic is_mem_op(input logic [4:0] opcode);
        return (opcode == OP_LOAD) || (opcode == OP_STORE);
    endfunction

    function automatic logic is_misaligned(input logic [4:0] opcode, input logic [2:0] func3,
                                           input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        if (MISALIGN_CHECK && is_mem_op(opcode)) begin
            case (acc_size(opcode, func3))
                SZ_H:    mis = addr_lo[0];
                SZ_W:    mis = |addr_lo;
                default: mis = 1'b0;
            endcase
        end
        return mis;
    endfunction

    stage_t  s_q;
    state_e  state_q;
    state_e  state_d;
    logic    capture;
    logic    ex_access;
    logic    s_is_load;
    logic    s_is_store;
    logic    s_mis;
    size_e   s_size;
    logic [1:0]      s_lo;
    logic [3:0]      strb_raw;
    logic [XLEN-1:0] wdata_raw;
    logic [XLEN-1:0] rshift;
    logic [XLEN-1:0] load_val;

    assign mem_stall = (state_q == ACCESS) && !dmem_ready;
    assign capture   = !mem_stall;
    assign ex_access = ex_valid && is_mem_op(ex_opcode)
                       && !is_misaligned(ex_opcode, ex_func3, ex_alu_out[1:0]);

    assign s_is_load  = (s_q.opcode == OP_LOAD);
    assign s_is_store = (s_q.opcode == OP_STORE);
    assign s_mis      = is_misaligned(s_q.opcode, s_q.func3, s_q.alu_out[1:0]);
    assign s_size     = acc_size(s_q.opcode, s_q.func3);
    assign s_lo       = s_q.alu_out[1:0];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: decided whenever the stage register captures a new instruction
    always_comb begin
        state_d = state_q;
        if (capture) begin
            state_d = ex_access ? ACCESS : IDLE;
        end
    end

    // EX/MEM stage register, held while an access is outstanding
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q <= '0;
        end else if (capture) begin
            s_q.valid     <= ex_valid;
            s_q.opcode    <= ex_opcode;
            s_q.func3     <= ex_func3;
            s_q.alu_out   <= ex_alu_out;
            s_q.rs2       <= ex_rs2_data;
            s_q.rd        <= ex_rd;
            s_q.reg_write <= ex_reg_write;
        end
    end

    // Store lane strobes and replicated data
    always_comb begin
        strb_raw  = 4'b0000;
        wdata_raw = s_q.rs2;
        case (s_size)
            SZ_B: begin
                strb_raw  = 4'b0001 << s_lo;
                wdata_raw = {4{s_q.rs2[7:0]}};
            end
            SZ_H: begin
                strb_raw  = 4'b0011 << s_lo;
                wdata_raw = {2{s_q.rs2[15:0]}};
            end
            default: begin
                strb_raw  = 4'b1111;
                wdata_raw = s_q.rs2;
            end
        endcase
    end

    assign dmem_req   = (state_q == ACCESS);
    assign dmem_we    = dmem_req && s_is_store;
    assign dmem_wstrb = dmem_we ? strb_raw : 4'b0000;
    assign dmem_wdata = wdata_raw;
    assign dmem_addr  = DMEM_AW'({s_q.alu_out[XLEN-1:2], 2'b00});

    // Load lane select and sign/zero extension
    assign rshift = dmem_rdata >> {s_lo, 3'b000};
    always_comb begin
        load_val = dmem_rdata;
        case (s_size)
            SZ_B: load_val = s_q.func3[2] ? {24'b0, rshift[7:0]}
                                          : {{24{rshift[7]}}, rshift[7:0]};
            SZ_H: load_val = s_q.func3[2] ? {16'b0, rshift[15:0]}
                                          : {{16{rshift[15]}}, rshift[15:0]};
            default: load_val = dmem_rdata;
        endcase
    end

    // Write-back register; IDLE means S retires (or is a bubble) at this edge
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid       <= 1'b0;
            wb_reg_write   <= 1'b0;
            wb_rd          <= 5'd0;
            wb_data        <= '0;
            mem_misaligned <= 1'b0;
        end else begin
            wb_valid       <= 1'b0;
            wb_reg_write   <= 1'b0;
            mem_misaligned <= 1'b0;
            if (state_q == IDLE) begin
                wb_valid       <= s_q.valid;
                wb_rd          <= s_q.rd;
                wb_data        <= s_q.alu_out;
                wb_reg_write   <= s_q.valid && s_q.reg_write && !s_mis;
                mem_misaligned <= s_q.valid && s_mis;
            end else if (dmem_ready) begin
                wb_valid     <= 1'b1;
                wb_rd        <= s_q.rd;
                wb_data      <= s_is_load ? load_val : s_q.alu_out;
                wb_reg_write <= s_is_load && s_q.reg_write;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of single-instruction vectors plus
// hand sequences for wait states, back-to-back loads and reset mid-access.
module tb_mem_stage;

    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_STORE = 5'b01000;
    localparam logic [4:0] OP_ALU   = 5'b01100;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [4:0]  ex_opcode;
    logic [2:0]  ex_func3;
    logic [31:0] ex_alu_out;
    logic [31:0] ex_rs2_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        mem_stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        mem_misaligned;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic [31:0] wb_data;

    int n_checks = 0;
    int n_pass   = 0;

    mem_stage #(.MISALIGN_CHECK(1'b1), .DMEM_AW(32)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_func3(ex_func3),
        .ex_alu_out(ex_alu_out), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .mem_stall(mem_stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .mem_misaligned(mem_misaligned), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_reg_write(wb_reg_write), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] rdata;
        logic        req;
        logic        we;
        logic [31:0] exp_addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] wb_data;
        logic        wb_rw;
        logic        mis;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_ex(input logic [4:0] op, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] rs2, input logic [4:0] rd, input logic rw);
        ex_valid     = 1'b1;
        ex_opcode    = op;
        ex_func3     = f3;
        ex_alu_out   = addr;
        ex_rs2_data  = rs2;
        ex_rd        = rd;
        ex_reg_write = rw;
    endtask

    initial begin
        rst = 1'b1; ex_valid = 1'b0; ex_opcode = '0; ex_func3 = '0; ex_alu_out = '0;
        ex_rs2_data = '0; ex_rd = '0; ex_reg_write = 1'b0; dmem_ready = 1'b0; dmem_rdata = '0;

        vecs.push_back('{OP_ALU,   3'b000, 32'h0000_0005, 32'h0, 5'd3, 1'b1, 32'h0,
                         1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0000_0005, 1'b1, 1'b0});
        vecs.push_back('{OP_STORE, 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 5'd0, 1'b0, 32'h0,
                         1'b1, 1'b1, 32'h0000_1000, 4'b1000, 32'hDDDD_DDDD, 32'h0000_1003, 1'b0, 1'b0});
        vecs.push_back('{OP_STORE, 3'b001, 32'h0000_1002, 32'h1234_5678, 5'd0, 1'b0, 32'h0,
                         1'b1, 1'b1, 32'h0000_1000, 4'b1100, 32'h5678_5678, 32'h0000_1002, 1'b0, 1'b0});
        vecs.push_back('{OP_STORE, 3'b001, 32'h0000_1000, 32'h0000_BEEF, 5'd0, 1'b0, 32'h0,
                         1'b1, 1'b1, 32'h0000_1000, 4'b0011, 32'hBEEF_BEEF, 32'h0000_1000, 1'b0, 1'b0});
        vecs.push_back('{OP_STORE, 3'b010, 32'h0000_1004, 32'hCAFE_BABE, 5'd0, 1'b0, 32'h0,
                         1'b1, 1'b1, 32'h0000_1004, 4'b1111, 32'hCAFE_BABE, 32'h0000_1004, 1'b0, 1'b0});
        vecs.push_back('{OP_LOAD,  3'b000, 32'h0000_2002, 32'h0, 5'd5, 1'b1, 32'h0080_0000,
                         1'b1, 1'b0, 32'h0000_2000, 4'h0, 32'h0, 32'hFFFF_FF80, 1'b1, 1'b0});
        vecs.push_back('{OP_LOAD,  3'b100, 32'h0000_2002, 32'h0, 5'd5, 1'b1, 32'h0080_0000,
                         1'b1, 1'b0, 32'h0000_2000, 4'h0, 32'h0, 32'h0000_0080, 1'b1, 1'b0});
        vecs.push_back('{OP_LOAD,  3'b001, 32'h0000_2002, 32'h0, 5'd9, 1'b1, 32'h8001_0000,
                         1'b1, 1'b0, 32'h0000_2000, 4'h0, 32'h0, 32'hFFFF_8001, 1'b1, 1'b0});
        vecs.push_back('{OP_LOAD,  3'b101, 32'h0000_2002, 32'h0, 5'd9, 1'b1, 32'h8001_0000,
                         1'b1, 1'b0, 32'h0000_2000, 4'h0, 32'h0, 32'h0000_8001, 1'b1, 1'b0});
        vecs.push_back('{OP_LOAD,  3'b010, 32'h0000_2004, 32'h0, 5'd10, 1'b1, 32'h1234_5678,
                         1'b1, 1'b0, 32'h0000_2004, 4'h0, 32'h0, 32'h1234_5678, 1'b1, 1'b0});
        vecs.push_back('{OP_LOAD,  3'b011, 32'h0000_2008, 32'h0, 5'd11, 1'b1, 32'hA5A5_0F0F,
                         1'b1, 1'b0, 32'h0000_2008, 4'h0, 32'h0, 32'hA5A5_0F0F, 1'b1, 1'b0});
        vecs.push_back('{OP_LOAD,  3'b000, 32'h0000_2001, 32'h0, 5'd12, 1'b1, 32'h0000_7F00,
                         1'b1, 1'b0, 32'h0000_2000, 4'h0, 32'h0, 32'h0000_007F, 1'b1, 1'b0});
        vecs.push_back('{OP_LOAD,  3'b010, 32'h0000_3002, 32'h0, 5'd8, 1'b1, 32'h0,
                         1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0000_3002, 1'b0, 1'b1});
        vecs.push_back('{OP_LOAD,  3'b001, 32'h0000_3001, 32'h0, 5'd8, 1'b1, 32'h0,
                         1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0000_3001, 1'b0, 1'b1});
        vecs.push_back('{OP_STORE, 3'b000, 32'hFFFF_FFFF, 32'h0000_00EE, 5'd0, 1'b0, 32'h0,
                         1'b1, 1'b1, 32'hFFFF_FFFC, 4'b1000, 32'hEEEE_EEEE, 32'hFFFF_FFFF, 1'b0, 1'b0});
        vecs.push_back('{OP_ALU,   3'b000, 32'h0000_0077, 32'h0, 5'd0, 1'b1, 32'h0,
                         1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0000_0077, 1'b1, 1'b0});

        // Reset state
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_req",   32'(dmem_req), 32'd0);
        check("rst_we",    32'(dmem_we), 32'd0);
        check("rst_wstrb", 32'(dmem_wstrb), 32'd0);
        check("rst_wbv",   32'(wb_valid), 32'd0);
        check("rst_wbrw",  32'(wb_reg_write), 32'd0);
        check("rst_wbrd",  32'(wb_rd), 32'd0);
        check("rst_wbd",   wb_data, 32'd0);
        check("rst_mis",   32'(mem_misaligned), 32'd0);

        // Single-instruction vectors with an immediately ready memory
        foreach (vecs[i]) begin
            drive_ex(vecs[i].op, vecs[i].f3, vecs[i].addr, vecs[i].rs2, vecs[i].rd, vecs[i].rw);
            dmem_ready = 1'b1;
            dmem_rdata = vecs[i].rdata;
            tick();
            ex_valid = 1'b0;
            #1;
            check($sformatf("v%0d_stall", i), 32'(mem_stall), 32'd0);
            check($sformatf("v%0d_req", i), 32'(dmem_req), 32'(vecs[i].req));
            if (vecs[i].req) begin
                check($sformatf("v%0d_we", i), 32'(dmem_we), 32'(vecs[i].we));
                check($sformatf("v%0d_addr", i), dmem_addr, vecs[i].exp_addr);
                check($sformatf("v%0d_wstrb", i), 32'(dmem_wstrb), 32'(vecs[i].wstrb));
                if (vecs[i].we) begin
                    check($sformatf("v%0d_wdata", i), dmem_wdata, vecs[i].wdata);
                end
            end
            tick();
            check($sformatf("v%0d_wbv", i), 32'(wb_valid), 32'd1);
            check($sformatf("v%0d_wbrd", i), 32'(wb_rd), 32'(vecs[i].rd));
            check($sformatf("v%0d_wbd", i), wb_data, vecs[i].wb_data);
            check($sformatf("v%0d_wbrw", i), 32'(wb_reg_write), 32'(vecs[i].wb_rw));
            check($sformatf("v%0d_mis", i), 32'(mem_misaligned), 32'(vecs[i].mis));
            tick();
            check($sformatf("v%0d_wbv_off", i), 32'(wb_valid), 32'd0);
            check($sformatf("v%0d_mis_off", i), 32'(mem_misaligned), 32'd0);
        end

        // LW with three wait states, second LW queued behind it
        drive_ex(OP_LOAD, 3'b010, 32'h0000_4000, 32'h0, 5'd6, 1'b1);
        dmem_ready = 1'b0;
        tick();
        drive_ex(OP_LOAD, 3'b010, 32'h0000_4004, 32'h0, 5'd7, 1'b1);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("ws%0d_stall", k), 32'(mem_stall), 32'd1);
            check($sformatf("ws%0d_req", k), 32'(dmem_req), 32'd1);
            check($sformatf("ws%0d_addr", k), dmem_addr, 32'h0000_4000);
            check($sformatf("ws%0d_wstrb", k), 32'(dmem_wstrb), 32'd0);
            check($sformatf("ws%0d_wbv", k), 32'(wb_valid), 32'd0);
            tick();
        end
        dmem_ready = 1'b1;
        dmem_rdata = 32'h1111_1111;
        #1;
        check("ws_release_stall", 32'(mem_stall), 32'd0);
        tick();
        ex_valid   = 1'b0;
        dmem_rdata = 32'h2222_2222;
        #1;
        check("b2b_wbv",  32'(wb_valid), 32'd1);
        check("b2b_wbrd", 32'(wb_rd), 32'd6);
        check("b2b_wbd",  wb_data, 32'h1111_1111);
        check("b2b_req",  32'(dmem_req), 32'd1);
        check("b2b_addr", dmem_addr, 32'h0000_4004);
        tick();
        check("b2b2_wbv",  32'(wb_valid), 32'd1);
        check("b2b2_wbrd", 32'(wb_rd), 32'd7);
        check("b2b2_wbd",  wb_data, 32'h2222_2222);
        check("b2b2_req",  32'(dmem_req), 32'd0);
        tick();

        // Reset while an access is stalled; late ready must be ignored
        drive_ex(OP_LOAD, 3'b010, 32'h0000_5000, 32'h0, 5'd2, 1'b1);
        dmem_ready = 1'b0;
        tick();
        ex_valid = 1'b0;
        #1;
        check("rs_stall_pre", 32'(mem_stall), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dmem_ready = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        #1;
        check("rs_req",   32'(dmem_req), 32'd0);
        check("rs_stall", 32'(mem_stall), 32'd0);
        check("rs_wbv",   32'(wb_valid), 32'd0);
        tick();
        check("rs_wbv2",  32'(wb_valid), 32'd0);
        drive_ex(OP_ALU, 3'b000, 32'h0000_0009, 32'h0, 5'd4, 1'b1);
        tick();
        ex_valid = 1'b0;
        tick();
        check("rs_add_wbv",  32'(wb_valid), 32'd1);
        check("rs_add_wbrd", 32'(wb_rd), 32'd4);
        check("rs_add_wbd",  wb_data, 32'h0000_0009);
        check("rs_add_wbrw", 32'(wb_reg_write), 32'd1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
